// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction-fetch stage holding the PC and a registered IF/ID bundle
// handed to decode over valid/ready, with halt, back-pressure, redirect and an accept counter.
module riscv_fetch #(
  parameter int          XLEN          = 32,
  parameter int          IMEM_ADDR_BIT = 12,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
  input  logic [XLEN-1:0]          i_imem_instr,
  input  logic                     i_redir_valid,
  input  logic [XLEN-1:0]          i_redir_pc,
  output logic                     o_if_valid,
  input  logic                     i_if_ready,
  output logic [XLEN-1:0]          o_if_pc,
  output logic [XLEN-1:0]          o_if_instr,
  output logic                     o_misalign,
  output logic                     o_oob,
  output logic [31:0]              o_fetch_cnt
);
  logic [XLEN-1:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic            if_valid_q, if_valid_d, misalign_q, misalign_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;
  logic            accept, slot_free, fetch;
  always_comb begin
    accept      = if_valid_q & i_if_ready;
    slot_free   = ~if_valid_q | i_if_ready;
    fetch       = i_en & slot_free & ~i_redir_valid;
    pc_d        = pc_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    misalign_d  = 1'b0;
    fetch_cnt_d = fetch_cnt_q + {31'd0, accept};
    if (i_redir_valid) begin
      // The held bundle belongs to the wrong path, so it is squashed even when decode stalls.
      pc_d       = {i_redir_pc[XLEN-1:2], 2'b00};
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR[XLEN-1:0];
      misalign_d = |i_redir_pc[1:0];
    end else if (fetch) begin
      pc_d       = pc_q + XLEN'(4);
      if_pc_d    = pc_q;
      if_instr_d = i_imem_instr;
      if_valid_d = 1'b1;
    end else if (accept) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR[XLEN-1:0];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q        <= RESET_PC[XLEN-1:0];
      if_pc_q     <= '0;
      if_instr_q  <= NOP_INSTR[XLEN-1:0];
      if_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      if_valid_q  <= if_valid_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end
  assign o_imem_addr = pc_q[IMEM_ADDR_BIT-1:2];
  assign o_oob       = |pc_q[XLEN-1:IMEM_ADDR_BIT];
  assign o_if_valid  = if_valid_q;
  assign o_if_pc     = if_pc_q;
  assign o_if_instr  = if_instr_q;
  assign o_misalign  = misalign_q;
  assign o_fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed checks of riscv_fetch against an imem holding word k = k+0x100.
module tb_riscv_fetch;
  logic        clk = 1'b0;
  logic        rst, en, redir_valid, if_ready;
  logic [31:0] redir_pc, imem_instr, if_pc, if_instr, fetch_cnt;
  logic [9:0]  imem_addr;
  logic        if_valid, misalign, oob;
  int          checks = 0;
  int          errors = 0;

  riscv_fetch dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_imem_addr(imem_addr),
    .i_imem_instr(imem_instr), .i_redir_valid(redir_valid), .i_redir_pc(redir_pc),
    .o_if_valid(if_valid), .i_if_ready(if_ready), .o_if_pc(if_pc),
    .o_if_instr(if_instr), .o_misalign(misalign), .o_oob(oob), .o_fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;
  assign imem_instr = 32'h100 + {22'd0, imem_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] cnt);
    chk({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_instr"}, if_instr, ins);
    chk({tag, "_cnt"}, fetch_cnt, cnt);
  endtask

  initial begin
    rst = 1; en = 0; if_ready = 1; redir_valid = 0; redir_pc = 0;
    step(); step();
    bundle("reset", 0, 0, 32'h13, 0);
    chk("reset_mis", {31'd0, misalign}, 0);
    chk("reset_addr", {22'd0, imem_addr}, 0);
    rst = 0; en = 1;
    step(); bundle("f0", 1, 0, 32'h100, 0);
    step(); bundle("f1", 1, 4, 32'h101, 1);
    step(); bundle("f2", 1, 8, 32'h102, 2);
    if_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); bundle($sformatf("hold%0d", i), 1, 8, 32'h102, 2);
      chk("hold_addr", {22'd0, imem_addr}, 3);
    end
    if_ready = 1;
    step(); bundle("resume", 1, 12, 32'h103, 3);
    if_ready = 0; redir_valid = 1; redir_pc = 32'h40;
    step(); bundle("redir_sq", 0, 12, 32'h13, 3);
    chk("redir_mis", {31'd0, misalign}, 0);
    chk("redir_addr", {22'd0, imem_addr}, 16);
    redir_valid = 0; if_ready = 1;
    step(); bundle("redir_f", 1, 32'h40, 32'h110, 3);
    chk("redir_mis2", {31'd0, misalign}, 0);
    step(); bundle("redir_f2", 1, 32'h44, 32'h111, 4);
    redir_valid = 1; redir_pc = 32'h42;
    step(); chk("mis_pulse", {31'd0, misalign}, 1);
    bundle("mis_sq", 0, 32'h44, 32'h13, 5);
    redir_valid = 0;
    step(); chk("mis_clear", {31'd0, misalign}, 0);
    bundle("mis_f", 1, 32'h40, 32'h110, 5);
    en = 0;
    step(); bundle("drain", 0, 32'h40, 32'h13, 6);
    step(); bundle("halted", 0, 32'h40, 32'h13, 6);
    chk("halt_addr", {22'd0, imem_addr}, 32'h11);
    en = 1;
    step(); bundle("reen", 1, 32'h44, 32'h111, 6);
    redir_valid = 1; redir_pc = 32'h1000;
    step(); chk("oob_flag", {31'd0, oob}, 1);
    chk("oob_addr", {22'd0, imem_addr}, 0);
    bundle("oob_sq", 0, 32'h44, 32'h13, 7);
    redir_valid = 0;
    step(); bundle("oob_f", 1, 32'h1000, 32'h100, 7);
    chk("oob_still", {31'd0, oob}, 1);
    rst = 1; redir_valid = 1; redir_pc = 32'h80;
    step(); bundle("rst_redir", 0, 0, 32'h13, 0);
    chk("rst_addr", {22'd0, imem_addr}, 0);
    chk("rst_oob", {31'd0, oob}, 0);
    chk("rst_mis", {31'd0, misalign}, 0);
    rst = 0; redir_valid = 0;
    step(); bundle("post_rst", 1, 0, 32'h100, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
